// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the DataMemory port arbiter.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        StIdle   = 1'b0,
        StLocked = 1'b1
    } arb_state_e;

    localparam int unsigned ArbFixed = 0;
    localparam int unsigned ArbRr    = 1;

    // Width of a master index; never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating picker: first set request at or after start, modulo N.
module rr_pick #(
    parameter int unsigned N  = 2,
    parameter int unsigned IW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    // Scan N positions starting at the pointer, first hit wins.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        valid = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            if (!valid && req[(int'(start) + k) % int'(N)]) begin
                valid = 1'b1;
                idx   = IW'((int'(start) + k) % int'(N));
                gnt   = N'(1) << ((int'(start) + k) % int'(N));
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master arbiter in front of the single-ported synchronous DataMemory.
// Fixed-priority or round-robin selection, per-master burst lock, force override,
// and read-valid tagging back to the issuing master.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTERS  = 2,
    parameter int unsigned ADDR_W       = 32,
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned RR_MODE      = ArbFixed
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_MASTERS-1:0]           m_req,
    input  logic [NUM_MASTERS-1:0]           m_we,
    input  logic [NUM_MASTERS-1:0]           m_lock,
    input  logic [NUM_MASTERS*ADDR_W-1:0]    m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]    m_wdata,
    input  logic                             force_en,
    input  logic [idx_w(NUM_MASTERS)-1:0]    force_id,
    output logic [NUM_MASTERS-1:0]           m_gnt,
    output logic [NUM_MASTERS-1:0]           m_rvalid,
    output logic [DATA_W-1:0]                rdata,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    output logic                             mem_we,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic [idx_w(NUM_MASTERS)-1:0]    owner,
    output logic                             locked
);

    localparam int unsigned IW = idx_w(NUM_MASTERS);

    arb_state_e             state_q;
    logic [IW-1:0]          owner_q;
    logic [IW-1:0]          ptr_q;

    logic [NUM_MASTERS-1:0] pick_req;
    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_start;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

    logic [NUM_MASTERS-1:0] norm_gnt;
    logic [IW-1:0]          norm_idx;

    logic                   force_ok;
    logic                   lock_hit;
    logic                   norm_hit;

    logic [NUM_MASTERS-1:0] gnt;
    logic [IW-1:0]          gnt_idx;
    logic                   gnt_any;

    logic [NUM_MASTERS-1:0] rv_q [READ_LATENCY];

    // Fixed priority reuses the rotating picker: reverse the request vector and start at 0.
    always_comb begin
        pick_req = '0;
        for (int i = 0; i < int'(NUM_MASTERS); i++) begin
            pick_req[i] = (RR_MODE == ArbRr) ? m_req[i] : m_req[int'(NUM_MASTERS) - 1 - i];
        end
    end

    assign pick_start = (RR_MODE == ArbRr) ? ptr_q : '0;

    rr_pick #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_rr_pick (
        .req   (pick_req),
        .start (pick_start),
        .gnt   (pick_gnt),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    // Undo the bit reversal in fixed mode so grant and index refer to real masters.
    always_comb begin
        norm_gnt = '0;
        norm_idx = '0;
        if (RR_MODE == ArbRr) begin
            norm_gnt = pick_gnt;
            norm_idx = pick_idx;
        end else begin
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                norm_gnt[i] = pick_gnt[int'(NUM_MASTERS) - 1 - i];
            end
            norm_idx = IW'(NUM_MASTERS - 1 - 32'(pick_idx));
        end
    end

    // An out-of-range force_id never grants.
    assign force_ok = (32'(force_id) < NUM_MASTERS) && m_req[force_id];
    assign lock_hit = !force_en && (state_q == StLocked) && m_req[owner_q] && m_lock[owner_q];
    assign norm_hit = !force_en && !lock_hit && pick_valid;

    // Grant selection: force, then held lock, then normal arbitration.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        if (force_en) begin
            if (force_ok) begin
                gnt_any = 1'b1;
                gnt_idx = force_id;
                gnt     = NUM_MASTERS'(1) << force_id;
            end
        end else if (lock_hit) begin
            gnt_any = 1'b1;
            gnt_idx = owner_q;
            gnt     = NUM_MASTERS'(1) << owner_q;
        end else if (pick_valid) begin
            gnt_any = 1'b1;
            gnt_idx = norm_idx;
            gnt     = norm_gnt;
        end
    end

    // Memory-side mux from the granted master; everything held at 0 while in reset.
    always_comb begin
        m_gnt     = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (rst_n) begin
            m_gnt = gnt;
            for (int i = 0; i < int'(NUM_MASTERS); i++) begin
                if (gnt[i]) begin
                    mem_addr  = m_addr[i*ADDR_W +: ADDR_W];
                    mem_wdata = m_wdata[i*DATA_W +: DATA_W];
                    mem_we    = m_we[i];
                end
            end
        end
    end

    // Lock state machine with owner and round-robin pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            owner_q <= '0;
            ptr_q   <= '0;
        end else begin
            if (gnt_any) begin
                owner_q <= gnt_idx;
            end
            // Pointer only advances on normally arbitrated grants.
            if (norm_hit && (RR_MODE == ArbRr)) begin
                ptr_q <= (32'(norm_idx) == NUM_MASTERS - 1) ? '0 : norm_idx + 1'b1;
            end
            if (force_en) begin
                state_q <= StIdle;
            end else if (lock_hit) begin
                state_q <= StLocked;
            end else if (norm_hit && m_lock[norm_idx]) begin
                state_q <= StLocked;
            end else begin
                state_q <= StIdle;
            end
        end
    end

    // Read-valid pipeline matching the memory read latency; writes enter as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(READ_LATENCY); i++) begin
                rv_q[i] <= '0;
            end
        end else begin
            rv_q[0] <= gnt & ~m_we;
            for (int i = 1; i < int'(READ_LATENCY); i++) begin
                rv_q[i] <= rv_q[i-1];
            end
        end
    end

    assign m_rvalid = rv_q[READ_LATENCY-1];
    assign rdata    = mem_rdata;
    assign owner    = owner_q;
    assign locked   = (state_q == StLocked);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench: three arbiter configurations sharing one clock.
//   a: N=2 fixed priority, latency 1
//   b: N=4 round-robin, latency 3
//   c: N=3 round-robin, latency 2 (lock, force, mid-stream reset)
module tb_mem_port_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- instance a ----------------
    logic        a_rst_n, a_force_en, a_force_id, a_mem_we, a_owner, a_locked;
    logic [1:0]  a_req, a_we, a_lock, a_gnt, a_rvalid;
    logic [63:0] a_addr, a_wdata;
    logic [31:0] a_rdata, a_mem_addr, a_mem_wdata, a_mem_rdata;

    mem_port_arbiter #(
        .NUM_MASTERS(2), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(1), .RR_MODE(0)
    ) dut_a (
        .clk(clk), .rst_n(a_rst_n), .m_req(a_req), .m_we(a_we), .m_lock(a_lock),
        .m_addr(a_addr), .m_wdata(a_wdata), .force_en(a_force_en), .force_id(a_force_id),
        .m_gnt(a_gnt), .m_rvalid(a_rvalid), .rdata(a_rdata), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata),
        .owner(a_owner), .locked(a_locked)
    );

    // ---------------- instance b ----------------
    logic         b_rst_n, b_force_en, b_mem_we, b_locked;
    logic [1:0]   b_force_id, b_owner;
    logic [3:0]   b_req, b_we, b_lock, b_gnt, b_rvalid;
    logic [127:0] b_addr, b_wdata;
    logic [31:0]  b_rdata, b_mem_addr, b_mem_wdata, b_mem_rdata;

    mem_port_arbiter #(
        .NUM_MASTERS(4), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(3), .RR_MODE(1)
    ) dut_b (
        .clk(clk), .rst_n(b_rst_n), .m_req(b_req), .m_we(b_we), .m_lock(b_lock),
        .m_addr(b_addr), .m_wdata(b_wdata), .force_en(b_force_en), .force_id(b_force_id),
        .m_gnt(b_gnt), .m_rvalid(b_rvalid), .rdata(b_rdata), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata),
        .owner(b_owner), .locked(b_locked)
    );

    // ---------------- instance c ----------------
    logic        c_rst_n, c_force_en, c_mem_we, c_locked;
    logic [1:0]  c_force_id, c_owner;
    logic [2:0]  c_req, c_we, c_lock, c_gnt, c_rvalid;
    logic [95:0] c_addr, c_wdata;
    logic [31:0] c_rdata, c_mem_addr, c_mem_wdata, c_mem_rdata;

    mem_port_arbiter #(
        .NUM_MASTERS(3), .ADDR_W(32), .DATA_W(32), .READ_LATENCY(2), .RR_MODE(1)
    ) dut_c (
        .clk(clk), .rst_n(c_rst_n), .m_req(c_req), .m_we(c_we), .m_lock(c_lock),
        .m_addr(c_addr), .m_wdata(c_wdata), .force_en(c_force_en), .force_id(c_force_id),
        .m_gnt(c_gnt), .m_rvalid(c_rvalid), .rdata(c_rdata), .mem_addr(c_mem_addr),
        .mem_wdata(c_mem_wdata), .mem_we(c_mem_we), .mem_rdata(c_mem_rdata),
        .owner(c_owner), .locked(c_locked)
    );

    logic [3:0] b_exp_rv;

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0; c_rst_n = 1'b0;
        a_req = 2'b11; a_we = '0; a_lock = '0; a_force_en = 1'b0; a_force_id = 1'b0;
        a_addr = {32'h20, 32'h10}; a_wdata = {32'h55, 32'h44}; a_mem_rdata = 32'hABCD_0123;
        b_req = '0; b_we = '0; b_lock = '0; b_force_en = 1'b0; b_force_id = '0;
        b_addr = {32'h10C, 32'h108, 32'h104, 32'h100}; b_wdata = '0; b_mem_rdata = '0;
        c_req = '0; c_we = '0; c_lock = '0; c_force_en = 1'b0; c_force_id = '0;
        c_addr = {32'h300, 32'h200, 32'h100}; c_wdata = '0; c_mem_rdata = '0;

        // Reset gating: requests present but nothing may be granted.
        #2;
        check("a_rst_gnt", 64'(a_gnt), 64'h0);
        check("a_rst_we", 64'(a_mem_we), 64'h0);
        check("a_rst_addr", 64'(a_mem_addr), 64'h0);
        check("a_rst_owner", 64'(a_owner), 64'h0);
        check("a_rst_locked", 64'(a_locked), 64'h0);
        check("a_rst_rvalid", 64'(a_rvalid), 64'h0);
        tick();
        tick();
        a_rst_n = 1'b1; b_rst_n = 1'b1; c_rst_n = 1'b1;

        // a: fixed priority, master 1 always wins, m0 starved.
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("a_gnt[%0d]", k), 64'(a_gnt), 64'h2);
            check($sformatf("a_addr[%0d]", k), 64'(a_mem_addr), 64'h20);
            check($sformatf("a_rv[%0d]", k), 64'(a_rvalid), (k == 0) ? 64'h0 : 64'h2);
            tick();
        end
        check("a_owner", 64'(a_owner), 64'h1);
        check("a_rdata", 64'(a_rdata), 64'hABCD_0123);
        a_we = 2'b10;
        #1;
        check("a_wr_we", 64'(a_mem_we), 64'h1);
        check("a_wr_wdata", 64'(a_mem_wdata), 64'h55);
        tick();
        a_req = 2'b00; a_we = 2'b00;
        #1;
        check("a_wr_no_rv", 64'(a_rvalid), 64'h0);
        check("a_idle_gnt", 64'(a_gnt), 64'h0);
        check("a_idle_addr", 64'(a_mem_addr), 64'h0);
        tick();

        // b: round-robin over 4 masters, wraps 3 -> 0, reads return 3 cycles later.
        b_req = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            if (k == 8) b_req = 4'b0000;
            #1;
            b_exp_rv = (k >= 3 && k < 11) ? (4'b0001 << ((k - 3) % 4)) : 4'b0000;
            check($sformatf("b_gnt[%0d]", k), 64'(b_gnt),
                  (k < 8) ? 64'(4'b0001 << (k % 4)) : 64'h0);
            if (k < 8) begin
                check($sformatf("b_addr[%0d]", k), 64'(b_mem_addr), 64'(32'h100 + 4 * (k % 4)));
            end
            check($sformatf("b_rv[%0d]", k), 64'(b_rvalid), 64'(b_exp_rv));
            tick();
        end

        // b: latency, reads m0@t, m1@t+1, write m0@t+2.
        b_req = 4'b0001; b_we = 4'b0000;
        #1;
        check("b_lat_g0", 64'(b_gnt), 64'h1);
        tick();
        b_req = 4'b0010;
        #1;
        check("b_lat_g1", 64'(b_gnt), 64'h2);
        tick();
        b_req = 4'b0001; b_we = 4'b0001;
        #1;
        check("b_lat_g2", 64'(b_gnt), 64'h1);
        check("b_lat_we", 64'(b_mem_we), 64'h1);
        check("b_lat_rv2", 64'(b_rvalid), 64'h0);
        tick();
        b_req = 4'b0000; b_we = 4'b0000;
        #1;
        check("b_lat_rv3", 64'(b_rvalid), 64'h1);
        tick();
        #1;
        check("b_lat_rv4", 64'(b_rvalid), 64'h2);
        tick();
        #1;
        check("b_lat_rv5", 64'(b_rvalid), 64'h0);
        tick();

        // c: move pointer to 2 via a single m1 grant.
        c_req = 3'b010;
        #1;
        check("c_pre_gnt", 64'(c_gnt), 64'h2);
        tick();
        // c: m2 locks for 4 cycles while everyone requests.
        c_req = 3'b111; c_lock = 3'b100;
        for (int k = 0; k < 4; k++) begin
            #1;
            check($sformatf("c_lock_gnt[%0d]", k), 64'(c_gnt), 64'h4);
            check($sformatf("c_lock_st[%0d]", k), 64'(c_locked), (k == 0) ? 64'h0 : 64'h1);
            tick();
        end
        c_lock = 3'b000;
        #1;
        check("c_unlock_gnt", 64'(c_gnt), 64'h1);
        check("c_unlock_st", 64'(c_locked), 64'h1);
        tick();
        #1;
        check("c_after_gnt", 64'(c_gnt), 64'h2);
        check("c_after_st", 64'(c_locked), 64'h0);
        tick();

        // c: m0 takes a lock, then force hands the port to m1.
        c_req = 3'b001; c_lock = 3'b001;
        #1;
        check("c_m0lock_gnt", 64'(c_gnt), 64'h1);
        tick();
        c_req = 3'b011; c_force_en = 1'b1; c_force_id = 2'd1;
        #1;
        check("c_force_locked", 64'(c_locked), 64'h1);
        check("c_force_gnt", 64'(c_gnt), 64'h2);
        check("c_force_addr", 64'(c_mem_addr), 64'h200);
        tick();
        check("c_force_unlock", 64'(c_locked), 64'h0);
        check("c_force_owner", 64'(c_owner), 64'h1);
        c_req = 3'b111; c_we = 3'b111; c_force_id = 2'd3;
        #1;
        check("c_force_oor_gnt", 64'(c_gnt), 64'h0);
        check("c_force_oor_we", 64'(c_mem_we), 64'h0);
        tick();
        c_req = '0; c_we = '0; c_lock = '0; c_force_en = 1'b0; c_force_id = '0;
        tick();

        // c: read by m0, then reset one cycle later.
        c_req = 3'b001;
        #1;
        check("c_rd_gnt", 64'(c_gnt), 64'h1);
        tick();
        c_rst_n = 1'b0; c_req = 3'b010;
        #1;
        check("c_rst_gnt", 64'(c_gnt), 64'h0);
        check("c_rst_rv", 64'(c_rvalid), 64'h0);
        check("c_rst_addr", 64'(c_mem_addr), 64'h0);
        check("c_rst_we", 64'(c_mem_we), 64'h0);
        check("c_rst_owner", 64'(c_owner), 64'h0);
        check("c_rst_locked", 64'(c_locked), 64'h0);
        tick();
        c_rst_n = 1'b1; c_req = 3'b000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check($sformatf("c_post_rv[%0d]", k), 64'(c_rvalid), 64'h0);
            tick();
        end
        // Pointer must be back at 0, so m0 wins.
        c_req = 3'b111;
        #1;
        check("c_post_ptr", 64'(c_gnt), 64'h1);
        tick();
        c_req = '0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
